// File: rtl/cc_collision_scanner.sv
// cc_collision_scanner: sequential row-by-row collision scan of a
// background matrix against a point (sprite) matrix.
//
// Ports:
//   CC_COLLISION_SCANNER_CLOCK_50     in   clock, rising edge
//   CC_COLLISION_SCANNER_RESET_InLow  in   async active-low reset
//   CC_COLLISION_SCANNER_START_In     in   scan request (IDLE only)
//   CC_COLLISION_SCANNER_BACK_InBUS   in   background, row r at [r*DW +: DW]
//   CC_COLLISION_SCANNER_POINT_InBUS  in   point matrix, same packing
//   CC_COLLISION_SCANNER_BUSY_Out     out  high while scanning
//   CC_COLLISION_SCANNER_DONE_Out     out  one-cycle result-valid pulse
//   CC_COLLISION_SCANNER_OutLow       out  0 = collision in last scan
//   CC_COLLISION_SCANNER_ROW_Out      out  lowest colliding row (0 if none)
//   CC_COLLISION_SCANNER_COUNT_Out    out  number of colliding rows
//
// Optional macro COLLISION_SCANNER_EARLYEXIT_EN: stop at the first
// colliding row (COUNT is then 1). Default: full scan.

module cc_collision_scanner #(
    parameter int COLLISION_SCANNER_DATAWIDTH = 8,
    parameter int COLLISION_SCANNER_ROWS      = 8,
    localparam int DW       = COLLISION_SCANNER_DATAWIDTH,
    localparam int ROWS     = COLLISION_SCANNER_ROWS,
    localparam int ROWIDX_W = $clog2(COLLISION_SCANNER_ROWS),
    localparam int COUNT_W  = $clog2(COLLISION_SCANNER_ROWS + 1)
) (
    input  logic                 CC_COLLISION_SCANNER_CLOCK_50,
    input  logic                 CC_COLLISION_SCANNER_RESET_InLow,
    input  logic                 CC_COLLISION_SCANNER_START_In,
    input  logic [ROWS*DW-1:0]   CC_COLLISION_SCANNER_BACK_InBUS,
    input  logic [ROWS*DW-1:0]   CC_COLLISION_SCANNER_POINT_InBUS,
    output logic                 CC_COLLISION_SCANNER_BUSY_Out,
    output logic                 CC_COLLISION_SCANNER_DONE_Out,
    output logic                 CC_COLLISION_SCANNER_OutLow,
    output logic [ROWIDX_W-1:0]  CC_COLLISION_SCANNER_ROW_Out,
    output logic [COUNT_W-1:0]   CC_COLLISION_SCANNER_COUNT_Out
);

    generate
        if (ROWS < 2 || ROWS > 64) begin : gBadRows
            $error("COLLISION_SCANNER_ROWS must be in 2..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ROWIDX_W-1:0] LAST_ROW = ROWIDX_W'(ROWS - 1);

    logic clk;
    logic rst_n;

    assign clk   = CC_COLLISION_SCANNER_CLOCK_50;
    assign rst_n = CC_COLLISION_SCANNER_RESET_InLow;

    state_t state;
    state_t stateNext;

    logic [DW-1:0]       backMem  [ROWS];
    logic [DW-1:0]       pointMem [ROWS];
    logic [ROWIDX_W-1:0] ptr;
    logic [COUNT_W-1:0]  cntAcc;
    logic [ROWIDX_W-1:0] firstRow;
    logic                hitSeen;

    logic                outLowReg;
    logic [ROWIDX_W-1:0] rowReg;
    logic [COUNT_W-1:0]  countReg;

    logic                rowHit;
    logic                lastRow;
    logic                scanEnd;
    logic [COUNT_W-1:0]  cntNext;
    logic [ROWIDX_W-1:0] firstNext;

    // Evaluation of the snapshot row under the pointer.
    assign rowHit  = |(backMem[ptr] & pointMem[ptr]);
    assign lastRow = (ptr == LAST_ROW);
    assign cntNext = cntAcc + COUNT_W'(rowHit);

    // Only the first hit latches its row index.
    assign firstNext = (rowHit && !hitSeen) ? ptr : firstRow;

`ifdef COLLISION_SCANNER_EARLYEXIT_EN
    assign scanEnd = lastRow | rowHit;
`else
    assign scanEnd = lastRow;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (CC_COLLISION_SCANNER_START_In) begin
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                if (scanEnd) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        CC_COLLISION_SCANNER_BUSY_Out = 1'b0;
        CC_COLLISION_SCANNER_DONE_Out = 1'b0;
        unique case (state)
            SCAN:    CC_COLLISION_SCANNER_BUSY_Out = 1'b1;
            DONE:    CC_COLLISION_SCANNER_DONE_Out = 1'b1;
            default: ;
        endcase
    end

    // Snapshot capture and scan accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                backMem[r]  <= '0;
                pointMem[r] <= '0;
            end
            ptr      <= '0;
            cntAcc   <= '0;
            firstRow <= '0;
            hitSeen  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CC_COLLISION_SCANNER_START_In) begin
                        for (int r = 0; r < ROWS; r++) begin
                            backMem[r]  <=
                                CC_COLLISION_SCANNER_BACK_InBUS[r*DW +: DW];
                            pointMem[r] <=
                                CC_COLLISION_SCANNER_POINT_InBUS[r*DW +: DW];
                        end
                        ptr      <= '0;
                        cntAcc   <= '0;
                        firstRow <= '0;
                        hitSeen  <= 1'b0;
                    end
                end
                SCAN: begin
                    cntAcc   <= cntNext;
                    firstRow <= firstNext;
                    hitSeen  <= hitSeen | rowHit;
                    // Pointer parks on the final row so it never
                    // runs past ROWS-1.
                    if (!scanEnd) begin
                        ptr <= ptr + ROWIDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Results publish on the edge entering DONE, folding in the
    // row evaluated on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outLowReg <= 1'b1;
            rowReg    <= '0;
            countReg  <= '0;
        end else if (state == SCAN && scanEnd) begin
            outLowReg <= ~(hitSeen | rowHit);
            rowReg    <= firstNext;
            countReg  <= cntNext;
        end
    end

    assign CC_COLLISION_SCANNER_OutLow      = outLowReg;
    assign CC_COLLISION_SCANNER_ROW_Out     = rowReg;
    assign CC_COLLISION_SCANNER_COUNT_Out   = countReg;

endmodule

// File: tb/tb_cc_collision_scanner.sv
// tb_cc_collision_scanner: directed vectors for the collision scanner,
// an 8x8 instance plus a 16-row, 4-bit instance.

module tb_cc_collision_scanner;

`ifdef COLLISION_SCANNER_EARLYEXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] back;
    logic [63:0] point;
    logic        busy;
    logic        done;
    logic        outLow;
    logic [2:0]  rowOut;
    logic [3:0]  countOut;

    logic        start16;
    logic [63:0] back16;
    logic [63:0] point16;
    logic        busy16;
    logic        done16;
    logic        outLow16;
    logic [3:0]  rowOut16;
    logic [4:0]  countOut16;

    int total;
    int bad;

    cc_collision_scanner #(
        .COLLISION_SCANNER_DATAWIDTH(8),
        .COLLISION_SCANNER_ROWS(8)
    ) dut (
        .CC_COLLISION_SCANNER_CLOCK_50(clk),
        .CC_COLLISION_SCANNER_RESET_InLow(rst_n),
        .CC_COLLISION_SCANNER_START_In(start),
        .CC_COLLISION_SCANNER_BACK_InBUS(back),
        .CC_COLLISION_SCANNER_POINT_InBUS(point),
        .CC_COLLISION_SCANNER_BUSY_Out(busy),
        .CC_COLLISION_SCANNER_DONE_Out(done),
        .CC_COLLISION_SCANNER_OutLow(outLow),
        .CC_COLLISION_SCANNER_ROW_Out(rowOut),
        .CC_COLLISION_SCANNER_COUNT_Out(countOut)
    );

    cc_collision_scanner #(
        .COLLISION_SCANNER_DATAWIDTH(4),
        .COLLISION_SCANNER_ROWS(16)
    ) dut16 (
        .CC_COLLISION_SCANNER_CLOCK_50(clk),
        .CC_COLLISION_SCANNER_RESET_InLow(rst_n),
        .CC_COLLISION_SCANNER_START_In(start16),
        .CC_COLLISION_SCANNER_BACK_InBUS(back16),
        .CC_COLLISION_SCANNER_POINT_InBUS(point16),
        .CC_COLLISION_SCANNER_BUSY_Out(busy16),
        .CC_COLLISION_SCANNER_DONE_Out(done16),
        .CC_COLLISION_SCANNER_OutLow(outLow16),
        .CC_COLLISION_SCANNER_ROW_Out(rowOut16),
        .CC_COLLISION_SCANNER_COUNT_Out(countOut16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fill8(input logic [7:0] v);
        logic [63:0] b;
        for (int r = 0; r < 8; r++) b[r*8 +: 8] = v;
        return b;
    endfunction

    // Start one scan on the 8-row instance; lat counts edges after
    // the START edge until DONE is seen, busyCyc the BUSY cycles.
    task automatic runScan(input logic [63:0] b,
                           input logic [63:0] p,
                           input bit corrupt,
                           input bit extraStart,
                           output int lat,
                           output int busyCyc);
        @(negedge clk);
        back  = b;
        point = p;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (corrupt) point = '1;
        lat = 0;
        busyCyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busyCyc++;
            start = extraStart && (i == 2 || i == 5);
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    // Step past the DONE cycle back into IDLE.
    task automatic toIdle(input bit pulse);
        start = pulse;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count DONE pulses over n cycles.
    task automatic countDones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    int lat;
    int bc;
    int nd;
    int t0;
    int t1;
    int cyc;
    logic [63:0] b;
    logic [63:0] p;

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        back    = '0;
        point   = '0;
        start16 = 1'b0;
        back16  = '0;
        point16 = '0;

        #12;
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_outlow", outLow, 1);
        checkVal("rst_row", rowOut, 0);
        checkVal("rst_count", countOut, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // No overlap.
        runScan(fill8(8'hAA), fill8(8'h55), 0, 0, lat, bc);
        checkVal("noov_lat", lat, 8);
        checkVal("noov_busy", bc, 8);
        checkVal("noov_outlow", outLow, 1);
        checkVal("noov_row", rowOut, 0);
        checkVal("noov_count", countOut, 0);
        toIdle(0);

        // Two colliding rows, 2 and 6.
        b = '0;
        p = '0;
        b[2*8 +: 8] = 8'h18;
        b[6*8 +: 8] = 8'hFF;
        p[2*8 +: 8] = 8'h08;
        p[6*8 +: 8] = 8'h01;
        runScan(b, p, 0, 0, lat, bc);
        checkVal("multi_lat", lat, EE ? 3 : 8);
        checkVal("multi_busy", bc, EE ? 3 : 8);
        checkVal("multi_outlow", outLow, 0);
        checkVal("multi_row", rowOut, 2);
        checkVal("multi_count", countOut, EE ? 1 : 2);
        toIdle(0);

        // Only the last row collides.
        b = '0;
        p = '0;
        b[7*8 +: 8] = 8'h81;
        p[7*8 +: 8] = 8'h80;
        runScan(b, p, 0, 0, lat, bc);
        checkVal("last_lat", lat, 8);
        checkVal("last_outlow", outLow, 0);
        checkVal("last_row", rowOut, 7);
        checkVal("last_count", countOut, 1);
        toIdle(0);

        // Snapshot: point rewritten to all ones mid-scan.
        runScan(fill8(8'hFF), '0, 1, 0, lat, bc);
        checkVal("snap_lat", lat, 8);
        checkVal("snap_outlow", outLow, 1);
        checkVal("snap_count", countOut, 0);
        toIdle(0);
        point = '0;

        // Full overlap.
        runScan(fill8(8'hFF), fill8(8'hFF), 0, 0, lat, bc);
        checkVal("full_lat", lat, EE ? 1 : 8);
        checkVal("full_outlow", outLow, 0);
        checkVal("full_row", rowOut, 0);
        checkVal("full_count", countOut, EE ? 1 : 8);
        toIdle(0);

        // Extra START pulses during SCAN and DONE are ignored.
        runScan(fill8(8'h0F), fill8(8'h10), 0, 1, lat, bc);
        checkVal("ign_lat", lat, 8);
        toIdle(1);
        countDones(15, nd);
        checkVal("ign_nodone", nd, 0);
        checkVal("ign_busy", busy, 0);

        // START held: DONE every 10 cycles.
        @(negedge clk);
        back  = fill8(8'h01);
        point = fill8(8'h02);
        start = 1'b1;
        t0 = -1;
        t1 = -1;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                if (t0 < 0) t0 = cyc;
                else if (t1 < 0) t1 = cyc;
            end
            if (t1 >= 0) break;
        end
        start = 1'b0;
        checkVal("held_period", t1 - t0, 10);
        checkVal("held_first", t0, 9);
        countDones(12, nd);

        // Reset while scanning row 3 of a colliding scan;
        // previous results (collision) must revert too.
        b = '0;
        p = '0;
        b[5*8 +: 8] = 8'h01;
        p[5*8 +: 8] = 8'h01;
        runScan(b, p, 0, 0, lat, bc);
        checkVal("pre_outlow", outLow, 0);
        toIdle(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkVal("mid_busy", busy, 0);
        checkVal("mid_done", done, 0);
        checkVal("mid_outlow", outLow, 1);
        checkVal("mid_row", rowOut, 0);
        checkVal("mid_count", countOut, 0);
        @(negedge clk);
        rst_n = 1'b1;
        countDones(15, nd);
        checkVal("mid_nodone", nd, 0);

        // 16 rows x 4 bits, full overlap.
        @(negedge clk);
        back16  = '1;
        point16 = '1;
        start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done16) break;
        end
        checkVal("w16_lat", lat, EE ? 1 : 16);
        checkVal("w16_outlow", outLow16, 0);
        checkVal("w16_row", rowOut16, 0);
        checkVal("w16_count", countOut16, EE ? 1 : 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
